// File: rtl/miner_job_loader.sv
// Job loader: assembles a 608-bit mining frame from a 32-bit word stream and
// issues it to the miner core as a one-cycle job_valid pulse.
module miner_job_loader #(
    parameter int unsigned NWORDS  = 19,
    parameter int unsigned WORD_W  = 32,
    parameter bit          PREEMPT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WORD_W-1:0]        s_data,
    input  logic                     s_last,
    input  logic                     miner_busy,
    output logic                     job_valid,
    output logic [NWORDS*WORD_W-1:0] job_data,
    output logic                     frame_err,
    output logic [15:0]              jobs_issued
);

    localparam int unsigned FrameW  = NWORDS * WORD_W;
    localparam logic [4:0]  LastIdx = 5'(NWORDS - 1);

    typedef enum logic [1:0] {
        StCollect,
        StDrain,
        StHold,
        StIssue
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [FrameW-1:0]   asm_q;
    logic [FrameW-1:0]   job_data_q;
    logic                job_valid_q;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         jobs_q;
    logic                ready_en_q;
    logic                accept;
    logic                wr_en;

    // Ready stays low through reset and the first edge after release.
    assign s_ready = ready_en_q && ((state_q == StCollect) || (state_q == StDrain));
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_en       = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (count_q >= LastIdx) begin
                        count_d = '0;
                        if (s_last) begin
                            state_d = StHold;
                        end else begin
                            state_d     = StDrain;
                            frame_err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        count_d     = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            StDrain: begin
                if (accept && s_last) begin
                    state_d = StCollect;
                    count_d = '0;
                end
            end
            StHold: begin
                if (!miner_busy || PREEMPT) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StCollect;
            end
            default: begin
                state_d = StCollect;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            count_q     <= '0;
            asm_q       <= '0;
            job_data_q  <= '0;
            job_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            jobs_q      <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            state_q     <= state_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            job_valid_q <= (state_q == StIssue);
            if (wr_en && (count_q <= LastIdx)) begin
                asm_q[count_q*WORD_W +: WORD_W] <= s_data;
            end
            if (state_q == StIssue) begin
                job_data_q <= asm_q;
                jobs_q     <= jobs_q + 16'd1;
            end
        end
    end

    assign job_valid   = job_valid_q;
    assign job_data    = job_data_q;
    assign frame_err   = frame_err_q;
    assign jobs_issued = jobs_q;

endmodule

// File: doc/miner_job_loader.md
Name: miner_job_loader

Overview:
- Upstream neighbour of the miner core.
- Collects a mining job from a 32-bit host word stream (valid/ready/last) into a 608-bit frame: a 512-bit first block plus a 96-bit tail.
- Presents the frame on a registered bus with a one-cycle job_valid pulse, the miner's valid_i.
- Issues only when the miner is not busy, unless preemption is enabled; also reports framing errors and counts issued jobs.

Parameters:
- NWORDS, 19, words per frame; the frame is NWORDS*WORD_W bits (608).
- WORD_W, 32, stream word width.
- PREEMPT, 0, 1 = issue a complete frame regardless of miner_busy; 0 = wait for miner_busy low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  WORD_W  host word.
- s_last  in  1  marks the final word of a frame.
- miner_busy  in  1  miner busy flag.
- job_valid  out  1  one-cycle pulse, drives the miner's valid_i.
- job_data  out  NWORDS*WORD_W  job frame; [511:0] is block1, [607:512] is the tail.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- jobs_issued  out  16  count of issued jobs, wraps.

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = COLLECT, word count = 0.
  - assembly register = 0, job_data = 0.
  - job_valid = 0, frame_err = 0, jobs_issued = 0.
  - s_ready = 0 while rst_n is low. A ready-enable flop sets on the first clk edge after release, so s_ready = 1 from then on.
- Accept rule: a word is accepted on a clk edge where s_valid && s_ready. Word index k (0-based) is written to assembly[k*WORD_W +: WORD_W]. The count is 5 bits, saturating logic is not needed.
- State COLLECT, s_ready = 1:
  - Accept with s_last and k == NWORDS-1: go to HOLD, count := 0.
  - Accept with s_last and k < NWORDS-1 (short frame): frame_err pulses the next cycle, count := 0, stay in COLLECT. The partial data is discarded; job_data is unchanged.
  - Accept with !s_last and k == NWORDS-1 (long frame): frame_err pulses the next cycle, go to DRAIN.
- State DRAIN, s_ready = 1:
  - Accepted words are discarded.
  - An accepted word with s_last returns to COLLECT with count := 0.
- State HOLD, s_ready = 0:
  - Move to ISSUE when (!miner_busy || PREEMPT).
  - Otherwise stay in HOLD indefinitely; the frame is retained.
- State ISSUE, lasting one cycle:
  - On entry, job_data := assembly and job_valid = 1 for exactly one cycle.
  - jobs_issued increments (mod 2^16).
  - Next state is COLLECT.
- Timing:
  - Latency from acceptance of the last word at edge T with miner_busy low: state is HOLD after T, ISSUE after T+1.
  - job_valid and the new job_data are therefore visible from edge T+2; 2 cycles minimum.
  - job_data holds the last issued job until the next ISSUE, so it is stable while the miner runs.
- miner_busy is sampled only in HOLD. A change while in COLLECT, DRAIN or ISSUE has no effect.
- A reset mid-frame or mid-HOLD discards everything and returns to the reset values.
- s_valid with s_ready low: the word is not accepted, with no side effect. The host must hold the word.
- Unknown or illegal state encodings recover to COLLECT.

Test Plan:
1. Reset release, then 19 words 0x00000000..0x00000012 with s_last on word 18, miner_busy = 0:
   - job_valid is a single pulse 2 cycles after the last accept.
   - job_data[31:0] = 0, job_data[607:576] = 0x00000012.
   - jobs_issued = 1; s_ready is low only during HOLD/ISSUE.
2. Same frame with miner_busy = 1 for 50 cycles, then 0:
   - Loader stays in HOLD with s_ready = 0 and no job_valid.
   - job_valid pulses 2 cycles after miner_busy falls.
   - job_data equals the sent frame; the previous job_data is unchanged until then.
3. Short frame of 5 words with s_last on word 4, then a valid 19-word frame:
   - frame_err pulses once, jobs_issued does not change.
   - The second frame issues correctly with no residue from the first.
4. Long frame of 22 words with s_last on word 21:
   - frame_err pulses after word 18; words 19..21 are drained.
   - A following valid frame issues with jobs_issued incremented by 1.
5. PREEMPT = 1, miner_busy held at 1, two back-to-back valid frames:
   - Two job_valid pulses; job_data tracks each frame.
   - jobs_issued wraps 0xFFFF -> 0x0000 when preloaded via a sequence of 65536 jobs (or force).
6. rst_n asserted while 10 words of a frame are loaded:
   - All outputs return to reset values immediately.
   - After release, a fresh 19-word frame issues with job_data equal to that frame only.
